// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map, word payload and scheduler state encoding.
package max7219_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned DIGITS_W    = 64;
    localparam int unsigned INIT_WORDS  = 5;
    localparam int unsigned FRAME_WORDS = 8;

    localparam logic [7:0] ADDR_DIGIT0    = 8'h01;
    localparam logic [7:0] ADDR_DIGIT7    = 8'h08;
    localparam logic [7:0] ADDR_DECODE    = 8'h09;
    localparam logic [7:0] ADDR_INTENSITY = 8'h0A;
    localparam logic [7:0] ADDR_SCAN      = 8'h0B;
    localparam logic [7:0] ADDR_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] ADDR_TEST      = 8'h0F;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } max_word_t;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_FRAME = 2'd2
    } sched_state_e;

    // Init sequence: wake up, scan limit, raw segments, brightness, test off.
    function automatic max_word_t init_word(input logic [3:0] idx,
                                            input logic [3:0] intensity,
                                            input logic [2:0] scan_limit);
        max_word_t w;
        case (idx)
            4'd0:    w = '{addr: ADDR_SHUTDOWN,  data: 8'h01};
            4'd1:    w = '{addr: ADDR_SCAN,      data: 8'(scan_limit)};
            4'd2:    w = '{addr: ADDR_DECODE,    data: 8'h00};
            4'd3:    w = '{addr: ADDR_INTENSITY, data: 8'(intensity)};
            default: w = '{addr: ADDR_TEST,      data: 8'h00};
        endcase
        return w;
    endfunction

    function automatic max_word_t frame_word(input logic [2:0] idx,
                                             input logic [63:0] digits);
        max_word_t w;
        w.addr = ADDR_DIGIT0 + 8'(idx);
        w.data = digits[{idx, 3'b000} +: 8];
        return w;
    endfunction

endpackage

// File: rtl/max7219_serial_tx.sv
// Shifts one 16-bit word MSB first: 32 data/clock cycles, 1 load cycle, 1 idle cycle.
module max7219_serial_tx
    import max7219_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      start_i,
    input  max_word_t word_i,
    output logic      done_o,
    output logic      load_o,
    output logic      dout_o,
    output logic      sclk_o
);

    localparam int unsigned CNT_W        = 6;
    localparam int unsigned SHIFT_CYCLES = 2 * WORD_W;
    localparam int unsigned LAST_CYCLE   = SHIFT_CYCLES + 1;

    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nxt;
    logic [WORD_W-1:0] word_q, word_d;
    logic              load_q, load_d;
    logic              dout_q, dout_d;
    logic              sclk_q, sclk_d;
    logic              done_q, done_d;
    logic [3:0]        bit_idx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            word_q <= '0;
            load_q <= 1'b0;
            dout_q <= 1'b0;
            sclk_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
            load_q <= load_d;
            dout_q <= dout_d;
            sclk_q <= sclk_d;
            done_q <= done_d;
        end
    end

    // Outputs are decoded from the cycle index the counter is about to hold.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        load_d  = 1'b0;
        dout_d  = 1'b0;
        sclk_d  = 1'b0;
        done_d  = 1'b0;
        cnt_nxt = cnt_q + CNT_W'(1);
        bit_idx = 4'd15 - cnt_nxt[4:1];

        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            word_d = word_i;
            dout_d = word_i[WORD_W-1];
        end else if (busy_q) begin
            if (cnt_q == CNT_W'(LAST_CYCLE)) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_nxt;
                if (cnt_nxt < CNT_W'(SHIFT_CYCLES)) begin
                    dout_d = word_q[bit_idx];
                    sclk_d = cnt_nxt[0];
                end else if (cnt_nxt == CNT_W'(SHIFT_CYCLES)) begin
                    load_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign load_o = load_q;
    assign dout_o = dout_q;
    assign sclk_o = sclk_q;

endmodule

// File: rtl/max7219_frame_sched.sv
// Sequences MAX7219 init and 8-digit refresh frames, merging and prioritising requests.
module max7219_frame_sched
    import max7219_pkg::*;
#(
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_update_stb,
    input  logic                i_reinit_stb,
    input  logic [DIGITS_W-1:0] i_digits,
    output logic                o_serial_load,
    output logic                o_serial_dout,
    output logic                o_serial_clk,
    output logic                o_busy,
    output logic                o_init_done
);

    localparam logic [3:0] INIT_LAST  = 4'(INIT_WORDS - 1);
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_WORDS - 1);

    sched_state_e        state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic                wait_q, wait_d;
    logic [DIGITS_W-1:0] snap_q, snap_d;
    logic                upd_pend_q, upd_pend_d;
    logic                rei_pend_q, rei_pend_d;
    logic                init_done_q, init_done_d;
    logic                busy_q, busy_d;
    logic                tx_start_c;
    max_word_t           tx_word_c;
    logic                tx_done;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_INIT;
            idx_q       <= '0;
            wait_q      <= 1'b0;
            snap_q      <= '0;
            upd_pend_q  <= 1'b0;
            rei_pend_q  <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            snap_q      <= snap_d;
            upd_pend_q  <= upd_pend_d;
            rei_pend_q  <= rei_pend_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        snap_d      = snap_q;
        upd_pend_d  = upd_pend_q;
        rei_pend_d  = rei_pend_q;
        init_done_d = init_done_q;
        tx_start_c  = 1'b0;
        tx_word_c   = '0;

        // Requests arriving mid-sequence are parked; repeated strobes merge.
        if (state_q != S_IDLE) begin
            if (i_update_stb) upd_pend_d = 1'b1;
            if (i_reinit_stb) rei_pend_d = 1'b1;
        end

        case (state_q)
            S_INIT: begin
                if (!wait_q) begin
                    tx_start_c = 1'b1;
                    tx_word_c  = init_word(idx_q, INTENSITY, SCAN_LIMIT);
                    wait_d     = 1'b1;
                end else if (tx_done) begin
                    if (idx_q == INIT_LAST) begin
                        state_d     = S_IDLE;
                        idx_d       = '0;
                        wait_d      = 1'b0;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        tx_start_c = 1'b1;
                        tx_word_c  = init_word(idx_q + 4'd1, INTENSITY, SCAN_LIMIT);
                    end
                end
            end
            S_FRAME: begin
                if (tx_done) begin
                    if (idx_q == FRAME_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        wait_d  = 1'b0;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        tx_start_c = 1'b1;
                        tx_word_c  = frame_word(idx_q[2:0] + 3'd1, snap_q);
                    end
                end
            end
            S_IDLE: begin
                if (rei_pend_q || i_reinit_stb) begin
                    state_d     = S_INIT;
                    idx_d       = '0;
                    wait_d      = 1'b1;
                    rei_pend_d  = 1'b0;
                    upd_pend_d  = upd_pend_q | i_update_stb;
                    init_done_d = 1'b0;
                    tx_start_c  = 1'b1;
                    tx_word_c   = init_word(4'd0, INTENSITY, SCAN_LIMIT);
                end else if (upd_pend_q || i_update_stb) begin
                    state_d    = S_FRAME;
                    idx_d      = '0;
                    wait_d     = 1'b1;
                    upd_pend_d = 1'b0;
                    snap_d     = i_digits;
                    tx_start_c = 1'b1;
                    tx_word_c  = frame_word(3'd0, i_digits);
                end
            end
            default: begin
                state_d = S_INIT;
                idx_d   = '0;
                wait_d  = 1'b0;
            end
        endcase

        busy_d = !((state_d == S_IDLE) && !upd_pend_d && !rei_pend_d);
    end

    max7219_serial_tx u_tx (
        .clk_i   (i_clk),
        .rst_n_i (i_reset_n),
        .start_i (tx_start_c),
        .word_i  (tx_word_c),
        .done_o  (tx_done),
        .load_o  (o_serial_load),
        .dout_o  (o_serial_dout),
        .sclk_o  (o_serial_clk)
    );

    assign o_busy      = busy_q;
    assign o_init_done = init_done_q;

endmodule

// File: doc/max7219_frame_sched.md
MAX7219_FRAME_SCHED -- requirements
Module: max7219_frame_sched

Interface
REQ-001 SHALL have parameter INTENSITY, default 4'h8, which is the MAX7219 intensity register value sent during init.
REQ-002 SHALL have parameter SCAN_LIMIT, default 3'd7, which is the scan-limit register value (all 8 digits).
REQ-003 SHALL have port i_clk, input, 1 bit: the single system clock (~10 MHz).
REQ-004 SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_update_stb, input, 1 bit: one-cycle request to refresh all 8 digits.
REQ-006 SHALL have port i_reinit_stb, input, 1 bit: one-cycle request to rerun the init sequence.
REQ-007 SHALL have port i_digits, input, 64 bits: raw segment bytes, digitN = i_digits[8N+7:8N].
REQ-008 SHALL have port o_serial_load, output, 1 bit: MAX7219 LOAD/CS.
REQ-009 SHALL have port o_serial_dout, output, 1 bit: MAX7219 DIN.
REQ-010 SHALL have port o_serial_clk, output, 1 bit: MAX7219 CLK.
REQ-011 SHALL have port o_busy, output, 1 bit: high while an init sequence or frame is in progress.
REQ-012 SHALL have port o_init_done, output, 1 bit: high once the init sequence has completed.

Function
REQ-013 SHALL use states S_INIT, S_IDLE and S_FRAME, each with a 4-bit command index and a transmit-wait substate.
REQ-014 S_INIT SHALL send these 16-bit words {addr,data} in order: 0x0C01 (shutdown off), 0x0B00|SCAN_LIMIT, 0x0900 (no decode), 0x0A00|INTENSITY, 0x0F00 (test off); it SHALL then go to S_IDLE and set o_init_done.
REQ-015 S_FRAME SHALL send words {8'(N+1), digitN} for N = 0..7 in ascending order, then return to S_IDLE.
REQ-016 SHALL snapshot i_digits into a 64-bit register on the cycle S_FRAME is entered; later changes to i_digits SHALL NOT affect the frame in flight.
REQ-017 If i_update_stb arrives while busy, SHALL set one pending flag; further strobes SHALL merge into it; a pending frame SHALL start on the cycle after return to S_IDLE.
REQ-018 If i_reinit_stb arrives while busy, SHALL set a pending-reinit flag; the current word and sequence SHALL complete first.
REQ-019 Reinit SHALL have priority over update when both are pending or simultaneous; o_init_done SHALL clear when the reinit begins, and the pending update SHALL be kept.
REQ-020 i_update_stb before o_init_done SHALL be held pending; no digit word SHALL be sent before init completes.
REQ-021 Each word SHALL take exactly 34 cycles: for each of 16 bits, MSB first, dout is valid with serial_clk low for 1 cycle, then serial_clk high for 1 cycle (32 cycles); serial_load is high for 1 cycle (cycle 33); then 1 idle cycle (cycle 34).
REQ-022 The next word SHALL begin on the cycle after the idle cycle, so init takes 170 cycles and a frame takes 272 cycles.
REQ-023 o_busy SHALL be low only in S_IDLE with no pending flags.

Reset
REQ-024 While i_reset_n is low: state=S_INIT (index 0), pending flags=0, o_init_done=0, o_serial_load=0, o_serial_clk=0, o_serial_dout=0, o_busy=1.
REQ-025 After reset release, init SHALL start on the first i_clk edge; a reset during a word SHALL abort it immediately with no load pulse.

Structure
REQ-026 MAX7219 register addresses (0x01-0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x0F) and the state encoding SHALL be defined in a shared package (max7219_pkg).
REQ-027 The bit-level shifter SHALL be one sub-module, max7219_serial_tx, with a 16-bit word, a start/done handshake, and the three serial outputs.

Verification
REQ-028 Reset release with no strobes -> the mock decodes 0x0C01, 0x0B07, 0x0900, 0x0A08, 0x0F00 in order; o_init_done rises 170 cycles after reset release.
REQ-029 i_digits=0x7E30_6D79_3300_5B5F (example), one i_update_stb after init -> mock digit0..7 match the bytes, o_busy falls 272 cycles after the strobe.
REQ-030 3 i_update_stb pulses during one frame, with i_digits changed mid-frame -> exactly one extra frame, carrying the new i_digits; the first frame carries the snapshot.
REQ-031 i_reinit_stb and i_update_stb in the same cycle during a frame -> the frame completes, then the 5-word init, then one frame; o_init_done is low between them.
REQ-032 i_reset_n asserted at bit 7 of a digit word -> no load pulse; after release the init sequence restarts from 0x0C01.
REQ-033 Each word -> serial_clk shows exactly 16 rising edges while load is low, and load is high for exactly 1 cycle per word.
